psc_trigger_tx_mc: RTL

Multi-channel successor to the single-trigger PSC packet transmitter. It accepts up to 16 asynchronous EVR trigger inputs and frames one 10-byte PSC packet per trigger. Packets go out over one serial line with round-robin fairness, CRC-8 and lost-trigger reporting. When no trigger is pending it sends idle packets continuously. It sits between the EVR trigger outputs and the PSC fibre/serial driver, and runs on a single system clock with an internal bit-rate divider; no PLL-derived clocks are used.

---
 rtl/psc_trigger_tx_mc.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/psc_trigger_tx_mc.sv
// psc_trigger_tx_mc: round-robin multi-channel PSC trigger packet serializer with lost-trigger flags
// Byte 8 carries CRC-8 (poly 0x07) over bytes 1..7 when PSC_TX_CRC_EN is defined, else 8'h00.
module psc_trigger_tx_mc #(
  parameter int NUM_CH = 4,
  parameter int CLK_DIV = 50,
  parameter logic [7:0] SOP = 8'h3C,
  parameter logic [7:0] EOP = 8'hBC,
  parameter logic [7:0] TRIG_ADDR = 8'h70,
  parameter logic [7:0] IDLE_ADDR = 8'h40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] evr_trigger,
  output logic              psc_output,
  output logic              pkt_start,
  output logic              pkt_trig,
  output logic [3:0]        pkt_chan,
  output logic [NUM_CH-1:0] trig_lost
);
  typedef enum logic {ST_IDLE = 1'b0, ST_TRIG = 1'b1} state_t;
  localparam int DW = $clog2(CLK_DIV);
  state_t state, state_nxt;
  logic [NUM_CH-1:0] sync1, sync2, sync3, trig_edge, pending, lost, clr;
  logic [DW-1:0] div_cnt;
  logic tick, active, sel, pkt_end, any_pend, hi_hit;
  logic [3:0] byte_idx, bit_idx, last_ch, sel_ch, lo_ch, hi_ch;
  logic [31:0] seq, data;
  logic [7:0] status, addr0, crc, cur_byte;
  logic [9:0] sym;

  assign trig_edge = sync2 & ~sync3;
  assign any_pend = |pending;
  assign tick = div_cnt == DW'(CLK_DIV - 1);
  assign pkt_end = bit_idx == 4'd9 && byte_idx == 4'd9;
  // before the first packet the line idles, so the first tick is a selection point too
  assign sel = tick && (!active || pkt_end);
  assign pkt_trig = state == ST_TRIG;
  assign trig_lost = lost;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
      pending <= '0;
      lost <= '0;
    end else begin
      sync1 <= evr_trigger;
      sync2 <= sync1;
      sync3 <= sync2;
      pending <= trig_edge | (pending & ~clr);
      lost <= ~clr & (lost | (trig_edge & pending));
    end
  end

  // search channels above the last served one first, then wrap from channel 0
  always_comb begin
    lo_ch = '0;
    hi_ch = '0;
    hi_hit = 1'b0;
    clr = '0;
    for (int n = NUM_CH - 1; n >= 0; n--) begin
      if (pending[n] && 4'(n) > last_ch) begin
        hi_ch = 4'(n);
        hi_hit = 1'b1;
      end
      if (pending[n] && 4'(n) <= last_ch) lo_ch = 4'(n);
    end
    sel_ch = hi_hit ? hi_ch : lo_ch;
    for (int n = 0; n < NUM_CH; n++) clr[n] = sel && any_pend && sel_ch == 4'(n);
    state_nxt = sel ? (any_pend ? ST_TRIG : ST_IDLE) : state;
  end

  always_ff @(posedge clk) state <= !reset ? ST_IDLE : state_nxt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt <= '0;
      active <= 1'b0;
      byte_idx <= '0;
      bit_idx <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DW'(1);
      if (sel) begin
        active <= 1'b1;
        byte_idx <= '0;
        bit_idx <= '0;
      end else if (tick) begin
        bit_idx <= bit_idx == 4'd9 ? 4'd0 : bit_idx + 4'd1;
        if (bit_idx == 4'd9) byte_idx <= byte_idx + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pkt_start <= 1'b0;
      pkt_chan <= '0;
      last_ch <= 4'(NUM_CH - 1);
      seq <= '0;
      status <= '0;
      addr0 <= '0;
      data <= '0;
    end else begin
      pkt_start <= sel;
      if (sel) begin
        status <= any_pend ? {|(lost & clr), 3'b000, sel_ch} : 8'h00;
        addr0 <= any_pend ? TRIG_ADDR + {4'h0, sel_ch} : IDLE_ADDR;
        data <= any_pend ? seq : '0;
      end
      if (sel && any_pend) begin
        seq <= seq + 32'd1;
        last_ch <= sel_ch;
        pkt_chan <= sel_ch;
      end
    end
  end

`ifdef PSC_TX_CRC_EN
  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? {r[6:0], 1'b0} ^ 8'h07 : {r[6:0], 1'b0};
    return r;
  endfunction

  // folds each of bytes 1..7 in as its stop bit ends, ready before byte 8 starts
  always_ff @(posedge clk) begin
    if (!reset || sel) crc <= '0;
    else if (tick && bit_idx == 4'd9 && byte_idx >= 4'd1 && byte_idx <= 4'd7) crc <= crc8(crc, cur_byte);
  end
`else
  assign crc = 8'h00;
`endif

  always_comb begin
    case (byte_idx)
      4'd0: cur_byte = SOP;
      4'd1: cur_byte = status;
      4'd2: cur_byte = addr0;
      4'd4: cur_byte = data[31:24];
      4'd5: cur_byte = data[23:16];
      4'd6: cur_byte = data[15:8];
      4'd7: cur_byte = data[7:0];
      4'd8: cur_byte = crc;
      4'd9: cur_byte = EOP;
      default: cur_byte = 8'h00;
    endcase
  end

  assign sym = {1'b1, cur_byte, 1'b0};
  assign psc_output = !active || sym[bit_idx];
endmodule
